// File: rtl/drop_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : drop_controller                                             |
// | Description: Falling-block game sequencer: spawn, gravity and player     |
// |              steps, lock, row scan/shift and BCD scoring.                |
// | Options    : SOFT_DROP_SCORE_EN - player down steps each add 1 point.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module drop_controller #(
  parameter int unsigned CLK_PER_TICK = 6250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  velocity,
  input  logic [2:0]  move_req,
  input  logic        collide,
  input  logic        spawn_blocked,
  input  logic        row_full,
  input  logic        shift_done,
  output logic        step_en,
  output logic [2:0]  step_code,
  output logic        spawn,
  output logic        lock_pulse,
  output logic        shift_req,
  output logic [4:0]  row_idx,
  output logic [15:0] score_bcd,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_SPAWN     = 3'd0,
    S_SPAWN_CHK = 3'd1,
    S_FALL      = 3'd2,
    S_LOCK      = 3'd3,
    S_SCAN      = 3'd4,
    S_SHIFT     = 3'd5,
    S_SCORE     = 3'd6,
    S_OVER      = 3'd7
  } state_t;

  localparam logic [2:0] C_MV_DOWN  = 3'b010;
  localparam logic [2:0] C_MV_RIGHT = 3'b100;
  localparam logic [2:0] C_MV_NONE  = 3'b101;
  localparam logic [4:0] C_ROW_LAST = 5'd19;
  localparam int         CNT_W      = $clog2(4 * CLK_PER_TICK);

  state_t             r_state;
  logic [CNT_W-1:0]   r_grav;
  logic [2:0]         r_prev_move;
  logic               r_pend_valid;
  logic [2:0]         r_pend_code;
  logic [4:0]         r_row;
  logic [2:0]         r_lines;
  logic [15:0]        r_score;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_grav_nxt;
  logic               w_pend_valid_nxt;
  logic [2:0]         w_pend_code_nxt;
  logic [4:0]         w_row_nxt;
  logic [2:0]         w_lines_nxt;
  logic [15:0]        w_score_nxt;
  logic               w_step_en;
  logic [2:0]         w_step_cand;
  logic               w_spawn;
  logic               w_lock;
  logic               w_shift;
  logic [2:0]         w_mult;
  logic [CNT_W-1:0]   w_last;
  logic               w_tick;
  logic               w_move_edge;

  // Four-digit BCD add of a small value; any carry out of the top digit pins at 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [3:0] b);
    logic [15:0] r;
    logic [4:0]  d;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + ((i == 0) ? {1'b0, b} : 5'd0) + {4'd0, c};
      if (d > 5'd9) begin
        r[4*i +: 4] = 4'(d - 5'd10);
        c           = 1'b1;
      end else begin
        r[4*i +: 4] = d[3:0];
        c           = 1'b0;
      end
    end
    if (c) begin
      r = 16'h9999;
    end
    return r;
  endfunction

  function automatic logic [3:0] line_points(input logic [2:0] n);
    case (n)
      3'd0:    return 4'd0;
      3'd1:    return 4'd1;
      3'd2:    return 4'd3;
      3'd3:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  assign w_mult      = 3'd4 - {1'b0, velocity};
  assign w_last      = CNT_W'(CLK_PER_TICK * 32'(w_mult) - 32'd1);
  // >= rather than == so a velocity change mid-count cannot strand the counter past its wrap.
  assign w_tick      = (r_state == S_FALL) && (r_grav >= w_last);
  assign w_move_edge = (move_req != r_prev_move) && (move_req <= C_MV_RIGHT);

  always_comb begin
    w_state_nxt      = r_state;
    w_grav_nxt       = r_grav;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_code_nxt  = r_pend_code;
    w_row_nxt        = r_row;
    w_lines_nxt      = r_lines;
    w_score_nxt      = r_score;
    w_step_en        = 1'b0;
    w_step_cand      = C_MV_NONE;
    w_spawn          = 1'b0;
    w_lock           = 1'b0;
    w_shift          = 1'b0;

    case (r_state)
      S_SPAWN: begin
        w_spawn     = 1'b1;
        w_state_nxt = S_SPAWN_CHK;
      end

      S_SPAWN_CHK: begin
        w_grav_nxt       = '0;
        w_pend_valid_nxt = 1'b0;
        w_state_nxt      = spawn_blocked ? S_OVER : S_FALL;
      end

      S_FALL: begin
        w_grav_nxt = w_tick ? '0 : r_grav + CNT_W'(1);
        if (w_tick) begin
          w_step_cand = C_MV_DOWN;
          w_step_en   = ~collide;
          if (collide) begin
            w_state_nxt = S_LOCK;
          end
        end else if (r_pend_valid) begin
          w_step_cand      = r_pend_code;
          w_step_en        = ~collide;
          w_pend_valid_nxt = 1'b0;
          if (collide && (r_pend_code == C_MV_DOWN)) begin
            w_state_nxt = S_LOCK;
          end
`ifdef SOFT_DROP_SCORE_EN
          if (!collide && (r_pend_code == C_MV_DOWN)) begin
            w_score_nxt = bcd_add(r_score, 4'd1);
          end
`endif
        end
        // A fresh edge always overwrites whatever is still waiting.
        if (w_move_edge) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_code_nxt  = move_req;
        end
        if (w_state_nxt == S_LOCK) begin
          w_pend_valid_nxt = 1'b0;
        end
      end

      S_LOCK: begin
        w_lock      = 1'b1;
        w_lines_nxt = 3'd0;
        w_row_nxt   = C_ROW_LAST;
        w_state_nxt = S_SCAN;
      end

      S_SCAN: begin
        if (row_full) begin
          w_shift     = 1'b1;
          w_lines_nxt = (r_lines == 3'd4) ? r_lines : r_lines + 3'd1;
          w_state_nxt = S_SHIFT;
        end else if (r_row == 5'd0) begin
          w_state_nxt = S_SCORE;
        end else begin
          w_row_nxt = r_row - 5'd1;
        end
      end

      // row_idx is held so the row that dropped into place is scanned again.
      S_SHIFT: begin
        if (shift_done) begin
          w_state_nxt = S_SCAN;
        end
      end

      S_SCORE: begin
        w_score_nxt = bcd_add(r_score, line_points(r_lines));
        w_state_nxt = S_SPAWN;
      end

      S_OVER: begin
        w_state_nxt = S_OVER;
      end

      default: begin
        w_state_nxt = S_SPAWN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_SPAWN;
      r_grav       <= '0;
      r_prev_move  <= C_MV_NONE;
      r_pend_valid <= 1'b0;
      r_pend_code  <= C_MV_NONE;
      r_row        <= 5'd0;
      r_lines      <= 3'd0;
      r_score      <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_grav       <= w_grav_nxt;
      r_prev_move  <= move_req;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_code  <= w_pend_code_nxt;
      r_row        <= w_row_nxt;
      r_lines      <= w_lines_nxt;
      r_score      <= w_score_nxt;
    end
  end

  // Pulses are masked while reset is held so nothing leaks out of the reset cycle.
  assign step_en    = w_step_en & ~reset;
  assign step_code  = step_en ? w_step_cand : C_MV_NONE;
  assign spawn      = w_spawn & ~reset;
  assign lock_pulse = w_lock & ~reset;
  assign shift_req  = w_shift & ~reset;
  assign row_idx    = r_row;
  assign score_bcd  = r_score;
  assign game_over  = (r_state == S_OVER);
  assign state      = r_state;

endmodule
`default_nettype wire
